// File: rtl/logic_unit_pkg.sv
// Shared op encoding for the logic slice and the future ALU decoder.
// Op width is fixed; all eight codes are legal.
package logic_unit_pkg;

   localparam int OPW = 3;

   typedef enum logic [OPW-1:0] {
      OP_BUF  = 3'd0,
      OP_NOT  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_XOR  = 3'd4,
      OP_NAND = 3'd5,
      OP_NOR  = 3'd6,
      OP_XNOR = 3'd7
   } op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Request/response bundle of the pipelined logic unit.
// master drives operands and out_ready; slave is the unit itself.
interface logic_unit_pipe_if #(
   parameter int WIDTH = 8
);
   import logic_unit_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [OPW-1:0]   op;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             zero;
   logic             parity;

   modport master (
      output in_valid, op, in1, in2, out_ready,
      input  in_ready, out_valid, out, zero, parity
   );

   modport slave (
      input  in_valid, op, in1, in2, out_ready,
      output in_ready, out_valid, out, zero, parity
   );

endinterface

// File: rtl/logic_op_comb.sv
// Combinational bitwise op decode with zero/parity of the fresh result.
// Flags come from this result, never from registered state.
module logic_op_comb
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OPW-1:0]   i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_res,
   output logic             o_zero,
   output logic             o_parity
);

   logic [WIDTH-1:0] w_res;

   always_comb begin
      w_res = i_a;
      unique case (op_e'(i_op))
         OP_BUF:  w_res = i_a;
         OP_NOT:  w_res = ~i_a;
         OP_AND:  w_res = i_a & i_b;
         OP_OR:   w_res = i_a | i_b;
         OP_XOR:  w_res = i_a ^ i_b;
         OP_NAND: w_res = ~(i_a & i_b);
         OP_NOR:  w_res = ~(i_a | i_b);
         OP_XNOR: w_res = ~(i_a ^ i_b);
      endcase
   end

   assign o_res    = w_res;
   assign o_zero   = ~|w_res;
   assign o_parity = ^w_res;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic slice: output register plus one-entry skid buffer.
// in_ready is registered as the complement of next-cycle skid occupancy.
module logic_unit_pipe #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   logic_unit_pipe_if.slave   bus
);

   logic [WIDTH-1:0] w_res;
   logic             w_zero;
   logic             w_par;
   logic             w_acc;
   logic             w_drn;

   logic             r_or_v, w_or_v_n;
   logic [WIDTH-1:0] r_or_d, w_or_d_n;
   logic             r_or_z, w_or_z_n;
   logic             r_or_p, w_or_p_n;
   logic             r_sk_v, w_sk_v_n;
   logic [WIDTH-1:0] r_sk_d, w_sk_d_n;
   logic             r_sk_z, w_sk_z_n;
   logic             r_sk_p, w_sk_p_n;
   logic             r_in_ready;

   logic_op_comb #(.WIDTH(WIDTH)) u_op (
      .i_op     (bus.op),
      .i_a      (bus.in1),
      .i_b      (bus.in2),
      .o_res    (w_res),
      .o_zero   (w_zero),
      .o_parity (w_par)
   );

   assign w_acc = bus.in_valid & r_in_ready;
   assign w_drn = r_or_v & bus.out_ready;

   always_comb begin
      w_or_v_n = r_or_v;
      w_or_d_n = r_or_d;
      w_or_z_n = r_or_z;
      w_or_p_n = r_or_p;
      w_sk_v_n = r_sk_v;
      w_sk_d_n = r_sk_d;
      w_sk_z_n = r_sk_z;
      w_sk_p_n = r_sk_p;
      if (!r_or_v || (w_drn && !r_sk_v)) begin
         if (w_acc) begin
            w_or_v_n = 1'b1;
            w_or_d_n = w_res;
            w_or_z_n = w_zero;
            w_or_p_n = w_par;
         end else if (w_drn) begin
            w_or_v_n = 1'b0;
         end
      end else if (r_sk_v && w_drn) begin
         w_or_d_n = r_sk_d;
         w_or_z_n = r_sk_z;
         w_or_p_n = r_sk_p;
         w_sk_v_n = 1'b0;
      end else if (w_acc) begin
         // OR is stalled: park the new word in the skid slot
         w_sk_v_n = 1'b1;
         w_sk_d_n = w_res;
         w_sk_z_n = w_zero;
         w_sk_p_n = w_par;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_or_v     <= 1'b0;
         r_or_d     <= '0;
         r_or_z     <= 1'b0;
         r_or_p     <= 1'b0;
         r_sk_v     <= 1'b0;
         r_sk_d     <= '0;
         r_sk_z     <= 1'b0;
         r_sk_p     <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         r_or_v     <= w_or_v_n;
         r_or_d     <= w_or_d_n;
         r_or_z     <= w_or_z_n;
         r_or_p     <= w_or_p_n;
         r_sk_v     <= w_sk_v_n;
         r_sk_d     <= w_sk_d_n;
         r_sk_z     <= w_sk_z_n;
         r_sk_p     <= w_sk_p_n;
         r_in_ready <= ~w_sk_v_n;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_or_v;
   assign bus.out       = r_or_d;
   assign bus.zero      = r_or_z;
   assign bus.parity    = r_or_p;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe at WIDTH=8 and WIDTH=1.
// A queue model of in-flight words checks every output cycle.
module tb_logic_unit_pipe;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_fail   = 0;

   logic_unit_pipe_if #(.WIDTH(8)) b8 ();
   logic_unit_pipe_if #(.WIDTH(1)) b1 ();

   logic_unit_pipe #(.WIDTH(8)) u8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b8)
   );

   logic_unit_pipe #(.WIDTH(1)) u1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] lop(input int op, input logic [63:0] a,
                                       input logic [63:0] b, input int w);
      logic [63:0] r;
      logic [63:0] m;
      m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      case (op)
         0: r = a;
         1: r = ~a;
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = ~(a & b);
         6: r = ~(a | b);
         default: r = ~(a ^ b);
      endcase
      return r & m;
   endfunction

   logic [7:0] q8[$];
   logic       q1[$];
   int n_acc8 = 0;
   int n_drn8 = 0;

   // Occupancy model: out_valid iff >=1 word held, in_ready iff <2 held
   always @(negedge clk) begin
      if (!rst_n) begin
         q8.delete();
         chk("w8_rst_valid", 64'(b8.out_valid), 64'd0);
         chk("w8_rst_ready", 64'(b8.in_ready), 64'd1);
         chk("w8_rst_out", 64'(b8.out), 64'd0);
         chk("w8_rst_flags", {62'd0, b8.zero, b8.parity}, 64'd0);
      end else begin
         chk("w8_valid", 64'(b8.out_valid), 64'(q8.size() > 0));
         chk("w8_ready", 64'(b8.in_ready), 64'(q8.size() < 2));
         if (b8.out_valid && q8.size() > 0) begin
            chk("w8_out", 64'(b8.out), 64'(q8[0]));
            chk("w8_zero", 64'(b8.zero), 64'(q8[0] == 8'd0));
            chk("w8_par", 64'(b8.parity), 64'(^q8[0]));
         end
         if (b8.out_valid && b8.out_ready && q8.size() > 0) begin
            void'(q8.pop_front());
            n_drn8++;
         end
         if (b8.in_valid && b8.in_ready) begin
            q8.push_back(8'(lop(int'(b8.op), 64'(b8.in1), 64'(b8.in2), 8)));
            n_acc8++;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         q1.delete();
         chk("w1_rst_valid", 64'(b1.out_valid), 64'd0);
         chk("w1_rst_ready", 64'(b1.in_ready), 64'd1);
         chk("w1_rst_out", 64'(b1.out), 64'd0);
      end else begin
         chk("w1_valid", 64'(b1.out_valid), 64'(q1.size() > 0));
         chk("w1_ready", 64'(b1.in_ready), 64'(q1.size() < 2));
         if (b1.out_valid && q1.size() > 0) begin
            chk("w1_out", 64'(b1.out), 64'(q1[0]));
            chk("w1_zero", 64'(b1.zero), 64'(!q1[0]));
            chk("w1_par", 64'(b1.parity), 64'(q1[0]));
         end
         if (b1.out_valid && b1.out_ready && q1.size() > 0)
            void'(q1.pop_front());
         if (b1.in_valid && b1.in_ready)
            q1.push_back(1'(lop(int'(b1.op), 64'(b1.in1), 64'(b1.in2), 1)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send8(input int op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] e, input logic ez, input logic ep,
                        input string nm);
      b8.op        = 3'(op);
      b8.in1       = a;
      b8.in2       = b;
      b8.in_valid  = 1'b1;
      b8.out_ready = 1'b1;
      tick();
      b8.in_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_v"}, 64'(b8.out_valid), 64'd1);
      chk({nm, "_out"}, 64'(b8.out), 64'(e));
      chk({nm, "_z"}, 64'(b8.zero), 64'(ez));
      chk({nm, "_p"}, 64'(b8.parity), 64'(ep));
   endtask

   initial begin
      int guard;
      int base_acc;
      int base_drn;
      logic [7:0] ops_exp [8];
      ops_exp = '{8'hF0, 8'h0F, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3};

      rst_n = 1'b0;
      b8.in_valid = 1'b0; b8.op = '0; b8.in1 = '0; b8.in2 = '0;
      b8.out_ready = 1'b1;
      b1.in_valid = 1'b0; b1.op = '0; b1.in1 = '0; b1.in2 = '0;
      b1.out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 64'(b8.in_ready), 64'd1);
      chk("idle_valid", 64'(b8.out_valid), 64'd0);
      chk("idle_out", 64'(b8.out), 64'd0);

      send8(1, 8'hA5, 8'h00, 8'h5A, 1'b0, 1'b0, "not_a5");
      send8(4, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0, "xor_zero");
      for (int i = 0; i < 8; i++)
         send8(i, 8'hF0, 8'hCC, ops_exp[i], 1'b0, 1'b0, "op_table");
      chk("model_nand_pin", lop(5, 64'h1, 64'h3, 4), 64'hE);
      tick();

      // Async reset with a word held: outputs clear before the next edge
      b8.out_ready = 1'b0;
      b8.op = 3'd0; b8.in1 = 8'h77; b8.in_valid = 1'b1;
      tick();
      b8.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 64'(b8.out_valid), 64'd0);
      chk("async_out", 64'(b8.out), 64'd0);
      chk("async_ready", 64'(b8.in_ready), 64'd1);
      tick();
      rst_n = 1'b1;
      tick();

      // Backpressure: 11 in OR, 22 in skid, 33 held upstream
      b8.out_ready = 1'b0;
      b8.op = 3'd0; b8.in1 = 8'h11; b8.in_valid = 1'b1;
      tick();
      b8.in1 = 8'h22;
      tick();
      b8.in1 = 8'h33;
      tick();
      @(negedge clk);
      chk("bp_ready", 64'(b8.in_ready), 64'd0);
      chk("bp_out11", 64'(b8.out), 64'h11);
      b8.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_out22", 64'(b8.out), 64'h22);
      chk("bp_ready_back", 64'(b8.in_ready), 64'd1);
      tick();
      b8.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_out33", 64'(b8.out), 64'h33);
      @(negedge clk);
      chk("bp_empty", 64'(b8.out_valid), 64'd0);
      tick();

      // Random stream with random backpressure
      base_acc = n_acc8;
      guard = 0;
      while (n_acc8 - base_acc < 100 && guard < 5000) begin
         b8.in_valid  = 1'($urandom_range(0, 1));
         b8.op        = 3'($urandom_range(0, 7));
         b8.in1       = 8'($urandom);
         b8.in2       = 8'($urandom);
         b8.out_ready = ($urandom_range(0, 3) != 0);
         tick();
         guard++;
      end
      chk("rand_done", 64'(guard < 5000), 64'd1);
      b8.in_valid  = 1'b0;
      b8.out_ready = 1'b1;
      guard = 0;
      while (q8.size() > 0 && guard < 20) begin
         tick();
         guard++;
      end
      chk("rand_drained", 64'(q8.size()), 64'd0);

      // Full-rate streaming: one word per cycle in and out
      tick();
      base_acc = n_acc8;
      base_drn = n_drn8;
      for (int i = 0; i < 20; i++) begin
         b8.in_valid = 1'b1;
         b8.op       = 3'($urandom_range(0, 7));
         b8.in1      = 8'($urandom);
         b8.in2      = 8'($urandom);
         tick();
      end
      b8.in_valid = 1'b0;
      tick();
      tick();
      chk("stream_acc", 64'(n_acc8 - base_acc), 64'd20);
      chk("stream_drn", 64'(n_drn8 - base_drn), 64'd20);

      // WIDTH=1 behaves as the scalar NOT gate
      b1.op = 3'd1;
      b1.out_ready = 1'b1;
      b1.in1 = 1'b0; b1.in_valid = 1'b1;
      tick();
      b1.in1 = 1'b1;
      @(negedge clk);
      chk("w1_not0", 64'(b1.out), 64'd1);
      tick();
      b1.in1 = 1'b0;
      @(negedge clk);
      chk("w1_not1", 64'(b1.out), 64'd0);
      tick();
      b1.in_valid = 1'b0;
      @(negedge clk);
      chk("w1_not2", 64'(b1.out), 64'd1);
      tick();

      // Fill OR and skid, then reset: nothing may emerge afterwards
      b1.out_ready = 1'b0;
      b1.in1 = 1'b1; b1.in_valid = 1'b1;
      tick();
      b1.in1 = 1'b0;
      tick();
      b1.in_valid = 1'b0;
      @(negedge clk);
      chk("w1_full_ready", 64'(b1.in_ready), 64'd0);
      chk("w1_full_valid", 64'(b1.out_valid), 64'd1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("w1_async_valid", 64'(b1.out_valid), 64'd0);
      chk("w1_async_ready", 64'(b1.in_ready), 64'd1);
      tick();
      tick();
      rst_n = 1'b1;
      b1.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("w1_post_rst", 64'(b1.out_valid), 64'd0);
      end
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
